// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the five-stage MIPS core.
//   Collects stall requests (IF/ID/EX/MEM) and the MEM-stage exception code,
//   drives the per-stage hold vector, the flush pulse and the redirect PC,
//   and keeps a one-cycle post-flush RECOVER state, a stall watchdog and
//   performance counters.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stallreq_from_*     stall requests from IF, ID, EX, MEM
//   excepttype_i        final exception code from MEM (0 = none)
//   cp0_epc_i           forwarded EPC, target for ERET
//   stall[5:0]          hold bits: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush               clear every pipeline register this edge
//   new_pc              redirect target (0 unless flush)
//   stall_timeout       sticky watchdog flag
//   stall_cycles        cycles with any stall bit set
//   flush_count         number of flush pulses
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
    parameter logic [15:0] STALL_LIMIT = 16'd1024,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_if,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [5:0]  STALL_MEM = 6'b011111;
    localparam logic [5:0]  STALL_EX  = 6'b001111;
    localparam logic [5:0]  STALL_ID  = 6'b000111;
    localparam logic [5:0]  STALL_IF  = 6'b000111;
    localparam logic [31:0] EXC_ERET  = 32'h0000_000e;
    localparam logic [15:0] RUN_MAX   = STALL_LIMIT - 16'd1;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t      state, state_nxt;
    logic [15:0] run_cnt;
    logic        in_rec;

    assign in_rec = (state == RECOVER);

    // Output priority: reset, exception, MEM, EX, ID, IF. In RECOVER the
    // ID and EX stages hold bubbles, so their requests are stale and dropped.
    always_comb begin
        stall  = 6'b0;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (!rst) begin
            if (excepttype_i != 32'h0) begin
                flush = 1'b1;
                case (excepttype_i)
                    EXC_ERET:                    new_pc = cp0_epc_i;
                    32'h1, 32'h8, 32'ha,
                    32'hc, 32'hd:                new_pc = EXC_VECTOR;
                    default:                     new_pc = EXC_VECTOR;
                endcase
            end else if (stallreq_from_mem) begin
                stall = STALL_MEM;
            end else if (stallreq_from_ex && !in_rec) begin
                stall = STALL_EX;
            end else if (stallreq_from_id && !in_rec) begin
                stall = STALL_ID;
            end else if (stallreq_from_if) begin
                stall = STALL_IF;
            end
        end
    end

    // Any flush (including one issued from RECOVER) lands in RECOVER;
    // RECOVER otherwise lasts one cycle.
    always_comb begin
        state_nxt = RUN;
        if (flush) state_nxt = RECOVER;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            run_cnt       <= 16'h0;
            stall_timeout <= 1'b0;
            stall_cycles  <= '0;
            flush_count   <= '0;
        end else begin
            state <= state_nxt;

            // Watchdog: counts consecutive stalled cycles, saturates at the
            // trip point so the sticky flag keeps being re-asserted harmlessly.
            if (flush || stall == 6'b0) begin
                run_cnt <= 16'h0;
            end else begin
                if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 16'd1;
                if (run_cnt == RUN_MAX) stall_timeout <= 1'b1;
            end

            if (stall != 6'b0) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush)         flush_count  <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        sr_if, sr_id, sr_ex, sr_mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles, flush_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.EXC_VECTOR(32'h20), .STALL_LIMIT(16'd8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_if(sr_if), .stallreq_from_id(sr_id),
        .stallreq_from_ex(sr_ex), .stallreq_from_mem(sr_mem),
        .excepttype_i(exc), .cp0_epc_i(epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_timeout(stall_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs then settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic i_if, input logic i_id, input logic i_ex,
                         input logic i_mem, input logic [31:0] i_exc);
        sr_if = i_if; sr_id = i_id; sr_ex = i_ex; sr_mem = i_mem; exc = i_exc;
        #1;
    endtask

    initial begin
        rst = 1'b1; epc = 32'h0;
        drive(0, 0, 0, 1, 32'h8);
        // reset overrides exception and stall requests
        chk("rst_stall", {26'h0, stall}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_newpc", new_pc, 32'h0);
        tick(); tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        repeat (5) tick();
        chk("idle_stall", {26'h0, stall}, 32'h0);
        chk("idle_flush", {31'h0, flush}, 32'h0);
        chk("idle_newpc", new_pc, 32'h0);
        chk("idle_scyc", stall_cycles, 32'h0);
        chk("idle_fcnt", flush_count, 32'h0);
        chk("idle_tmo", {31'h0, stall_timeout}, 32'h0);

        // EX stall 3 cycles, ID also on 2nd: EX wins
        drive(0, 0, 1, 0, 32'h0);
        chk("ex_c1", {26'h0, stall}, 32'h0f);
        tick();
        chk("scyc_1", stall_cycles, 32'd1);
        drive(0, 1, 1, 0, 32'h0);
        chk("ex_c2", {26'h0, stall}, 32'h0f);
        tick();
        drive(0, 0, 1, 0, 32'h0);
        chk("ex_c3", {26'h0, stall}, 32'h0f);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk("ex_done", {26'h0, stall}, 32'h0);
        chk("scyc_3", stall_cycles, 32'd3);

        // syscall together with MEM stall: flush wins
        epc = 32'h1234;
        drive(0, 0, 0, 1, 32'h8);
        chk("sys_stall", {26'h0, stall}, 32'h0);
        chk("sys_flush", {31'h0, flush}, 32'h1);
        chk("sys_newpc", new_pc, 32'h20);
        tick();
        chk("sys_fcnt", flush_count, 32'd1);
        // RECOVER: ID and EX requests masked
        drive(0, 1, 1, 0, 32'h0);
        chk("rec_mask", {26'h0, stall}, 32'h0);
        chk("rec_noflush", {31'h0, flush}, 32'h0);
        chk("rec_newpc0", new_pc, 32'h0);
        tick();
        drive(0, 1, 0, 0, 32'h0);
        chk("run_id", {26'h0, stall}, 32'h07);
        tick();
        chk("scyc_4", stall_cycles, 32'd4);

        // ERET uses EPC
        drive(0, 0, 0, 0, 32'he);
        chk("eret_flush", {31'h0, flush}, 32'h1);
        chk("eret_newpc", new_pc, 32'h1234);
        tick();
        drive(0, 1, 0, 0, 32'h0);
        chk("eret_rec_id", {26'h0, stall}, 32'h0);
        tick();
        drive(0, 1, 0, 0, 32'h0);
        chk("eret_run_id", {26'h0, stall}, 32'h07);
        tick();

        // unlisted nonzero code goes to vector; IF honoured in RECOVER
        drive(0, 0, 0, 0, 32'h5);
        chk("oth_newpc", new_pc, 32'h20);
        tick();
        drive(1, 1, 0, 0, 32'h0);
        chk("rec_if", {26'h0, stall}, 32'h07);
        tick();
        drive(0, 0, 0, 1, 32'h0);
        chk("run_mem", {26'h0, stall}, 32'h1f);
        tick();
        chk("fcnt_3", flush_count, 32'd3);
        chk("scyc_7", stall_cycles, 32'd7);

        // back-to-back exceptions: interrupt then overflow
        drive(0, 0, 0, 0, 32'h1);
        chk("int_flush", {31'h0, flush}, 32'h1);
        chk("int_newpc", new_pc, 32'h20);
        tick();
        drive(0, 0, 1, 0, 32'hc);
        chk("ovf_flush", {31'h0, flush}, 32'h1);
        chk("ovf_newpc", new_pc, 32'h20);
        chk("ovf_stall", {26'h0, stall}, 32'h0);
        tick();
        chk("fcnt_5", flush_count, 32'd5);
        drive(0, 1, 0, 0, 32'h0);
        chk("rec2_mask", {26'h0, stall}, 32'h0);
        tick();
        drive(0, 1, 0, 0, 32'h0);
        chk("rec2_run", {26'h0, stall}, 32'h07);
        tick();
        drive(0, 0, 0, 0, 32'h0);
        tick();
        chk("scyc_8", stall_cycles, 32'd8);

        // watchdog with STALL_LIMIT=8
        drive(1, 0, 0, 0, 32'h0);
        repeat (7) tick();
        chk("wd_before", {31'h0, stall_timeout}, 32'h0);
        tick();
        chk("wd_trip", {31'h0, stall_timeout}, 32'h1);
        drive(0, 0, 0, 0, 32'h0);
        repeat (3) tick();
        chk("wd_sticky", {31'h0, stall_timeout}, 32'h1);
        chk("scyc_16", stall_cycles, 32'd16);

        // reset while in RECOVER clears everything and returns to RUN
        drive(0, 0, 0, 0, 32'hd);
        tick();
        rst = 1'b1;
        drive(1, 0, 0, 0, 32'h0);
        chk("rst_if", {26'h0, stall}, 32'h0);
        tick();
        rst = 1'b0;
        drive(0, 1, 0, 0, 32'h0);
        chk("rst_tmo", {31'h0, stall_timeout}, 32'h0);
        chk("rst_scyc", stall_cycles, 32'h0);
        chk("rst_fcnt", flush_count, 32'h0);
        chk("rst_run_id", {26'h0, stall}, 32'h07);
        tick();
        drive(0, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It collects stall requests from IF, ID, EX and MEM and exception reports from MEM. It drives the `stall[5:0]` vector and `flush` pulse consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb), and supplies the redirect PC. It also keeps the post-flush recovery state, a stall watchdog and performance counters.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0020, handler entry address for all non-ERET exceptions
- `STALL_LIMIT`, 16'd1024, consecutive stalled cycles before watchdog trips
- `CNT_W`, 32, width of performance counters

Ports:
- `clk` in 1: clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `stallreq_from_if` in 1: instruction bus not ready
- `stallreq_from_id` in 1: load-use hazard
- `stallreq_from_ex` in 1: multi-cycle op (div, madd/msub) busy
- `stallreq_from_mem` in 1: data bus not ready
- `excepttype_i` in 32: final exception type from MEM; 0 = none
- `cp0_epc_i` in 32: EPC value (forwarded) for ERET
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold
- `flush` out 1: clear all pipeline registers this edge
- `new_pc` out 32: redirect target, valid only when `flush`=1
- `stall_timeout` out 1: sticky watchdog flag
- `stall_cycles` out CNT_W: count of cycles with `stall`≠0
- `flush_count` out CNT_W: count of flush pulses

## Operation
- `stall`, `flush` and `new_pc` are combinational from the inputs and state. Counters, the watchdog and the FSM are registered.
- Priority, highest first:
  - `rst`: outputs are 0.
  - `excepttype_i`≠0: `flush`=1, `stall`=0.
  - `stallreq_from_mem`: 6'b011111.
  - `stallreq_from_ex`: 6'b001111.
  - `stallreq_from_id`: 6'b000111.
  - `stallreq_from_if`: 6'b000111.
  - Otherwise `stall`=0.
- `new_pc` selection:
  - 32'h0000_000e (ERET): `cp0_epc_i`.
  - 0x1 (interrupt), 0x8 (syscall), 0xa (invalid inst), 0xc (overflow), 0xd (trap): `EXC_VECTOR`.
  - Any other nonzero code: `EXC_VECTOR`.
  - When `flush`=0: 0.
- FSM states are RUN and RECOVER.
  - RUN → RECOVER on any cycle with `flush`=1.
  - RECOVER → RUN unconditionally after one cycle.
  - In RECOVER, `stallreq_from_id` and `stallreq_from_ex` are ignored because ID and EX hold bubbles. IF/MEM requests and exceptions are still honoured.
  - A new exception in RECOVER flushes again and stays in RECOVER.
- Watchdog: `run_cnt` (16 bit) increments each cycle with `stall`≠0 and clears on any cycle with `stall`=0 or `flush`=1.
  - When `run_cnt` reaches `STALL_LIMIT`−1 while stalled, `stall_timeout` sets on that edge.
  - `stall_timeout` holds until `rst`. `run_cnt` saturates.
- Counters:
  - `stall_cycles` increments when `stall`≠0.
  - `flush_count` increments when `flush`=1.
  - Both wrap at 2^CNT_W.

## Timing
- Reset values: `stall`=0, `flush`=0, `new_pc`=0, `stall_timeout`=0, `stall_cycles`=0, `flush_count`=0, FSM=RUN, `run_cnt`=0.
- Combinational outputs have zero latency. The pipeline registers sample them on the same edge.
- `flush` is exactly one cycle per exception cycle presented. An exception held for k cycles gives k flushes (MEM clears itself, so normally 1).
- RECOVER lasts exactly the one cycle after the flush edge.
- Simultaneous exception and any stall request: flush wins and `stall`=0.
- `rst` mid-stall or in RECOVER: returns to RUN and clears all counters on that edge.

## Test plan
- Reset, then idle 5 cycles → `stall`=0, `flush`=0, `new_pc`=0, counters 0.
- `stallreq_from_ex`=1 for 3 cycles, with `stallreq_from_id`=1 on the 2nd cycle → `stall`=6'b001111 all 3 cycles; `stall_cycles`=3.
- `stallreq_from_mem`=1 with `excepttype_i`=0x8 in the same cycle → `stall`=0, `flush`=1, `new_pc`=0x20; next cycle `flush_count`=1 and FSM in RECOVER.
- `excepttype_i`=0xe, `cp0_epc_i`=0x1234 → `new_pc`=0x1234. Next cycle `stallreq_from_id`=1 → `stall`=0 (masked). Cycle after, `stallreq_from_id`=1 → `stall`=6'b000111.
- `STALL_LIMIT`=8 with `stallreq_from_if` held 8 cycles → `stall_timeout` rises after the 8th edge. It stays 1 after the request drops and clears only on `rst`.
- Exception on two consecutive cycles (0x1 then 0xc) → two flush pulses, `new_pc`=0x20 both, `flush_count`=2, FSM stays RECOVER then returns to RUN.
